// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 FFT stage sequencer.
//   fsm_state_t : sequencer states (IDLE, RUN, DRAIN, DONE)
//   DRAIN_W     : width of the drain counter (covers a pipeline latency of 0..15)
//   addr_w/tw_w/stage_w : port widths derived from LOG2N
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fsm_state_t;

   localparam int unsigned DRAIN_W = 4;

   // Memory address width: one bit per stage.
   function automatic int unsigned addr_w(input int unsigned log2n);
      return log2n;
   endfunction

   // Twiddle index width: N/2 twiddles.
   function automatic int unsigned tw_w(input int unsigned log2n);
      return log2n - 1;
   endfunction

   // Stage index width.
   function automatic int unsigned stage_w(input int unsigned log2n);
      return $clog2(log2n);
   endfunction

endpackage

// File: rtl/radix2_addr_gen.sv
// Combinational in-place address and twiddle generator for one radix-2 butterfly.
//   stage  : current stage s
//   k      : butterfly index within the stage (0..N/2-1)
//   addr_a : upper input address = grp*2*half + pos
//   addr_b : lower input address = addr_a + half
//   tw_idx : twiddle ROM index   = pos << (LOG2N-1-s)
module radix2_addr_gen
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N = 4
) (
   input  logic [stage_w(LOG2N)-1:0] stage,
   input  logic [tw_w(LOG2N)-1:0]    k,
   output logic [addr_w(LOG2N)-1:0]  addr_a,
   output logic [addr_w(LOG2N)-1:0]  addr_b,
   output logic [tw_w(LOG2N)-1:0]    tw_idx
);

   localparam int unsigned AW  = addr_w(LOG2N);
   localparam int unsigned TW  = tw_w(LOG2N);
   localparam int unsigned WW  = 2 * AW;

   logic [AW-1:0] half;
   logic [AW-1:0] kw;
   logic [AW-1:0] pos;
   logic [AW-1:0] grp;
   logic [WW-1:0] tw_full;

   // half = 2^s splits k into position-in-group and group number.
   always_comb begin
      half    = AW'(1) << stage;
      kw      = AW'(k);
      pos     = kw & (half - AW'(1));
      grp     = kw >> stage;
      addr_a  = ((grp << 1) << stage) | pos;
      addr_b  = addr_a + half;
      // Shift left by LOG2N-1 then right by s avoids a subtraction in the shift amount.
      tw_full = (WW'(pos) << TW) >> stage;
      tw_idx  = TW'(tw_full);
   end

endmodule

// File: rtl/radix2_stage_sequencer.sv
// Radix-2 in-place FFT stage sequencer: walks every butterfly of every stage,
// presenting one op per handshake, and idles the datapath for PIPE_LAT cycles
// between stages so write-backs land before the next stage reads.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle request to run a transform (honoured in IDLE only)
//   busy, done  : transform in progress / one-cycle completion pulse
//   op_valid    : butterfly op presented; op_ready accepts it
//   op_addr_a/b : in-place memory addresses of the butterfly inputs
//   op_tw_idx   : twiddle ROM index
//   op_stage    : current stage index
//   op_last     : final butterfly of the current stage
module radix2_stage_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N    = 4,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       op_valid,
   input  logic                       op_ready,
   output logic [addr_w(LOG2N)-1:0]   op_addr_a,
   output logic [addr_w(LOG2N)-1:0]   op_addr_b,
   output logic [tw_w(LOG2N)-1:0]     op_tw_idx,
   output logic [stage_w(LOG2N)-1:0]  op_stage,
   output logic                       op_last
);

   localparam int unsigned AW = addr_w(LOG2N);
   localparam int unsigned KW = tw_w(LOG2N);
   localparam int unsigned SW = stage_w(LOG2N);
   localparam int unsigned DW = DRAIN_W;

   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

   fsm_state_t    state, state_nxt;
   logic [SW-1:0] s, s_nxt;
   logic [KW-1:0] k, k_nxt;
   logic [DW-1:0] drain, drain_nxt;

   logic [AW-1:0] gen_a, gen_b;
   logic [KW-1:0] gen_tw;
   logic          run_nxt, busy_nxt;

   // Next-state and counter update.
   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      k_nxt     = k;
      drain_nxt = drain;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               s_nxt     = '0;
               k_nxt     = '0;
            end
         end
         RUN: begin
            if (op_ready) begin
               if (k == K_LAST) begin
                  state_nxt = DRAIN;
                  k_nxt     = '0;
                  drain_nxt = DW'(PIPE_LAT);
               end else begin
                  k_nxt = k + KW'(1);
               end
            end
         end
         DRAIN: begin
            // Leaving on a count of 1 (or 0) makes DRAIN last max(PIPE_LAT,1) cycles.
            if (drain <= DW'(1)) begin
               drain_nxt = '0;
               if (s == S_LAST) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RUN;
                  s_nxt     = s + SW'(1);
               end
            end else begin
               drain_nxt = drain - DW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Addresses are computed from the next (s, k) so the op outputs can be registered.
   radix2_addr_gen #(
      .LOG2N (LOG2N)
   ) u_addr_gen (
      .stage  (s_nxt),
      .k      (k_nxt),
      .addr_a (gen_a),
      .addr_b (gen_b),
      .tw_idx (gen_tw)
   );

   assign run_nxt  = (state_nxt == RUN);
   assign busy_nxt = run_nxt || (state_nxt == DRAIN);

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s         <= '0;
         k         <= '0;
         drain     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         op_valid  <= 1'b0;
         op_last   <= 1'b0;
         op_addr_a <= '0;
         op_addr_b <= '0;
         op_tw_idx <= '0;
         op_stage  <= '0;
      end else begin
         state     <= state_nxt;
         s         <= s_nxt;
         k         <= k_nxt;
         drain     <= drain_nxt;
         busy      <= busy_nxt;
         done      <= (state_nxt == DONE);
         op_valid  <= run_nxt;
         op_last   <= run_nxt && (k_nxt == K_LAST);
         op_addr_a <= run_nxt ? gen_a  : '0;
         op_addr_b <= run_nxt ? gen_b  : '0;
         op_tw_idx <= run_nxt ? gen_tw : '0;
         op_stage  <= busy_nxt ? s_nxt : '0;
      end
   end

endmodule

// File: tb/tb_radix2_stage_sequencer.sv
// Self-checking bench for radix2_stage_sequencer (LOG2N=3). A main instance
// (PIPE_LAT=2) is scoreboarded against the expected op table; two extra
// instances (PIPE_LAT=0 and 5) share start/reset for drain-gap checks.
module tb_radix2_stage_sequencer;

   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic [1:0] tw;
      logic [1:0] stage;
      logic       last;
   } op_t;

   logic clk, rst_n, start, op_ready;

   logic       m_busy, m_done, m_valid, m_last;
   logic [2:0] m_a, m_b;
   logic [1:0] m_tw, m_stage;

   logic       x0_busy, x0_done, x0_valid, x0_last;
   logic [2:0] x0_a, x0_b;
   logic [1:0] x0_tw, x0_stage;

   logic       x5_busy, x5_done, x5_valid, x5_last;
   logic [2:0] x5_a, x5_b;
   logic [1:0] x5_tw, x5_stage;

   radix2_stage_sequencer #(.LOG2N(3), .PIPE_LAT(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(m_busy), .done(m_done),
      .op_valid(m_valid), .op_ready(op_ready), .op_addr_a(m_a), .op_addr_b(m_b),
      .op_tw_idx(m_tw), .op_stage(m_stage), .op_last(m_last));

   radix2_stage_sequencer #(.LOG2N(3), .PIPE_LAT(0)) u_dut_lat0 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(x0_busy), .done(x0_done),
      .op_valid(x0_valid), .op_ready(1'b1), .op_addr_a(x0_a), .op_addr_b(x0_b),
      .op_tw_idx(x0_tw), .op_stage(x0_stage), .op_last(x0_last));

   radix2_stage_sequencer #(.LOG2N(3), .PIPE_LAT(5)) u_dut_lat5 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(x5_busy), .done(x5_done),
      .op_valid(x5_valid), .op_ready(1'b1), .op_addr_a(x5_a), .op_addr_b(x5_b),
      .op_tw_idx(x5_tw), .op_stage(x5_stage), .op_last(x5_last));

   int  checks = 0;
   int  errors = 0;
   op_t exp_q[$];
   int  busy_cycles = 0;
   int  done_cnt = 0;

   int ea[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int eb[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int etw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   int  exp_gap[3] = '{2, 1, 5};
   int  gap[3];
   bit  in_gap[3];
   bit  prev_stall;
   op_t held;

   bit  bp_mode = 1'b0;
   int  bp_idx = 0;
   int  bp_pat[4] = '{1, 0, 0, 1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // op_ready driver: always ready, or the 1,0,0,1 backpressure pattern.
   initial begin
      op_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            op_ready = (bp_pat[bp_idx % 4] != 0);
            bp_idx++;
         end else begin
            op_ready = 1'b1;
         end
      end
   end

   // Output monitor: scoreboard pop, stall stability, busy/done accounting, drain gaps.
   always @(negedge clk) begin
      op_t obs, e;
      logic [2:0] vld, rdy, lst, dn;
      obs = '{a: m_a, b: m_b, tw: m_tw, stage: m_stage, last: m_last};
      vld = {x5_valid, x0_valid, m_valid};
      rdy = {1'b1, 1'b1, op_ready};
      lst = {x5_last, x0_last, m_last};
      dn  = {x5_done, x0_done, m_done};
      if (!rst_n) begin
         prev_stall = 1'b0;
         for (int i = 0; i < 3; i++) in_gap[i] = 1'b0;
      end else begin
         if (prev_stall) chk("stall_hold", 32'(obs), 32'(held));
         if (m_valid && op_ready) begin
            if (exp_q.size() == 0) begin
               chk("op_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("op", 32'(obs), 32'(e));
            end
         end
         prev_stall = m_valid && !op_ready;
         held = obs;
         if (m_busy) busy_cycles++;
         if (m_done) begin
            done_cnt++;
            chk("busy_low_in_done", 32'(m_busy), 32'd0);
         end
         for (int i = 0; i < 3; i++) begin
            if (in_gap[i]) begin
               if (vld[i]) begin
                  chk($sformatf("drain_gap%0d", i), 32'(gap[i]), 32'(exp_gap[i]));
                  in_gap[i] = 1'b0;
               end else begin
                  gap[i]++;
               end
               if (dn[i]) in_gap[i] = 1'b0;
            end
            if (vld[i] && rdy[i] && lst[i]) begin
               in_gap[i] = 1'b1;
               gap[i] = 0;
            end
         end
      end
   end

   task automatic pulse_start(input bit push);
      op_t e;
      @(posedge clk);
      #1;
      start = 1'b1;
      if (push) begin
         busy_cycles = 0;
         done_cnt = 0;
         for (int i = 0; i < 12; i++) begin
            e.a = 3'(ea[i]);
            e.b = 3'(eb[i]);
            e.tw = 2'(etw[i]);
            e.stage = 2'(i / 4);
            e.last = ((i % 4) == 3);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (15) @(negedge clk);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_stage1();
      int n = 0;
      while (m_stage != 2'd1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reached_stage1", 32'(m_stage), 32'd1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  32'(m_busy),  32'd0);
      chk("rst_done",  32'(m_done),  32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_last",  32'(m_last),  32'd0);
      chk("rst_addr",  32'({m_a, m_b, m_tw, m_stage}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_wait_busy", 32'(m_busy), 32'd0);

      // Scenario 1: full transform, always ready.
      pulse_start(1'b1);
      wait_done();
      chk("busy_cycles", 32'(busy_cycles), 32'd18);

      // Scenario 2: backpressure.
      bp_mode = 1'b1;
      pulse_start(1'b1);
      wait_done();
      bp_mode = 1'b0;

      // Scenario 4: start while busy is ignored.
      pulse_start(1'b1);
      wait_stage1();
      pulse_start(1'b0);
      wait_done();
      chk("busy_cycles_restart", 32'(busy_cycles), 32'd18);

      // Start presented during the DONE cycle is ignored.
      pulse_start(1'b1);
      n = 0;
      while (!m_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 32'(m_done), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_in_done_busy", 32'(m_busy), 32'd0);
      chk("start_in_done_valid", 32'(m_valid), 32'd0);
      repeat (15) @(negedge clk);
      chk("queue_empty_done", 32'(exp_q.size()), 32'd0);

      // Scenario 5: reset mid stage 1.
      pulse_start(1'b1);
      wait_stage1();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  32'(m_busy),  32'd0);
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_last",  32'(m_last),  32'd0);
      chk("mid_rst_addr",  32'({m_a, m_b, m_tw, m_stage}), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
      chk("mid_rst_idle", 32'(m_busy), 32'd0);
      pulse_start(1'b1);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
